// File: rtl/register_dump_pkg.sv
// Shared sizes for the register dump engine: word width, register count and
// the beat index used by the checksum beat.
package register_dump_pkg;

  localparam int WORD        = 64;
  localparam int REG_COUNT   = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int OUT_INDEX_W = 6;

  localparam logic [OUT_INDEX_W-1:0] CSUM_INDEX = 6'd32;

endpackage : register_dump_pkg

// File: rtl/register_dump.sv
// Walks every architectural register through one synchronous read port and
// streams each value on a valid/ready interface. Optional XOR checksum beat
// is built in when REGDUMP_CHECKSUM_EN is defined.
module register_dump
  import register_dump_pkg::*;
#(
  parameter int NREGS = REG_COUNT,
  parameter int DW    = WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [REG_ADDR_W-1:0]  rd_reg,
  input  logic [DW-1:0]          rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [OUT_INDEX_W-1:0] out_index,
  output logic                   out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
`ifdef REGDUMP_CHECKSUM_EN
    CSUM    = 3'd4,
`endif
    DONE    = 3'd5
  } state_t;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NREGS - 1);

  state_t                state_reg;
  state_t                state_next;
  logic [REG_ADDR_W-1:0] idx_reg;
  logic                  fire;
  logic                  at_last;

  assign fire    = out_valid && out_ready;
  assign at_last = (idx_reg == LAST_IDX);
  assign rd_reg  = idx_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND: begin
        if (fire) begin
          if (!at_last) begin
            state_next = ISSUE;
          end else begin
`ifdef REGDUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM:    if (fire) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] csum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      csum_reg <= '0;
    end else if (state_reg == CAPTURE) begin
      csum_reg <= csum_reg ^ rd_data;
    end
  end
`endif

  // The beat is latched in CAPTURE so later read-port changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) idx_reg <= '0;
        end
        CAPTURE: begin
          out_data  <= rd_data;
          out_index <= {1'b0, idx_reg};
          out_valid <= 1'b1;
          out_last  <= at_last && !CSUM_EN;
        end
        SEND: begin
          if (fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (!at_last) idx_reg <= idx_reg + 1'b1;
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        // First CSUM cycle loads the beat; afterwards hold until accepted.
        CSUM: begin
          if (!out_valid) begin
            out_data  <= csum_reg;
            out_index <= CSUM_INDEX;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule : register_dump

// File: tb/tb_register_dump.sv
// Self-checking bench for register_dump with a synchronous-read register
// memory model; honours REGDUMP_CHECKSUM_EN when defined.
module tb_register_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_reg;
  logic [63:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;

  logic [63:0] mem [32];
  logic        toggle;
  int          total;
  int          bad;
  logic [63:0] csum_seen;

  typedef struct {
    logic [5:0]  idx;
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
  localparam int BASE_CYCLES = 99;
`else
  localparam bit CSUM_ON = 1'b0;
  localparam int BASE_CYCLES = 97;
`endif

  register_dump dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_reg    (rd_reg),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_reg];

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
      else        out_ready = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
    check({tag, "_data"},  out_data,       64'd0);
    check({tag, "_index"}, 64'(out_index), 64'd0);
    check({tag, "_rdreg"}, 64'(rd_reg),    64'd0);
  endtask

  // mode 0: plain, 1: ready toggling, 2: extra start at beat 10, 3: reset at beat 7
  task automatic run_dump(input int mode, input string name);
    beat_t       b;
    logic [63:0] acc;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [5:0]  prev_index;
    logic        poked;
    logic        got_done;
    int          n, beats, stalls, first_v;

    acc = '0;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 6'(i);
      b.data = mem[i];
      b.last = (i == 31) && !CSUM_ON;
      exp_q.push_back(b);
      acc ^= mem[i];
    end
    if (CSUM_ON) begin
      b.idx  = 6'd32;
      b.data = acc;
      b.last = 1'b1;
      exp_q.push_back(b);
    end

    beats = 0; stalls = 0; first_v = -1; poked = 1'b0; got_done = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_index = '0;

    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    for (n = 1; n <= 2000; n++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (n == 1) check({name, "_busy_up"}, 64'(busy), 64'd1);
      if (first_v < 0 && out_valid) first_v = n;
      if (prev_stall) begin
        check({name, "_stall_data"},  out_data,        prev_data);
        check({name, "_stall_index"}, 64'(out_index),  64'(prev_index));
        check({name, "_stall_valid"}, 64'(out_valid),  64'd1);
      end
      if (mode == 3 && out_valid && out_index == 6'd7) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs({name, "_midreset"});
        #1 rst_n = 1'b1;
        exp_q.delete();
        $display("dump %s: reset during beat 7", name);
        return;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_beat"}, 64'(out_index), 64'h3f);
        end else begin
          b = exp_q.pop_front();
          check({name, "_index"}, 64'(out_index), 64'(b.idx));
          check({name, "_data"},  out_data,       b.data);
          check({name, "_last"},  64'(out_last),  64'(b.last));
        end
        if (out_index == 6'd32) csum_seen = out_data;
        $display("beat %s idx=%0d data=%h last=%0d", name, out_index, out_data, out_last);
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_index = out_index;
      if (prev_stall) stalls++;
      if (mode == 2 && beats == 10 && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end

    if (!got_done) begin
      check({name, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({name, "_cycles"},  64'(n),       64'(BASE_CYCLES + stalls));
    check({name, "_first_v"}, 64'(first_v), 64'd3);
    check({name, "_beats"},   64'(beats),   64'(CSUM_ON ? 33 : 32));
    check({name, "_left"},    64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_busy_down"},  64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check({name, "_no_requeue"}, 64'(busy), 64'd0);
    $display("dump %s: cycles=%0d stalls=%0d beats=%0d", name, n, stalls, beats);
  endtask

  initial begin
    total = 0; bad = 0; toggle = 1'b0; csum_seen = '0;
    rst_n = 1'b0; start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 64'h1000 + 64'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    run_dump(0, "plain");
    toggle = 1'b1;
    run_dump(1, "toggle");
    toggle = 1'b0;
    run_dump(2, "restart");
    run_dump(3, "reset7");
    run_dump(0, "after_reset");

    mem[31] = 64'hDEAD_BEEF_0000_0031;
    run_dump(0, "reg31");

    if (CSUM_ON) begin
      for (int i = 0; i < 32; i++) mem[i] = 64'(i);
      run_dump(0, "csum_zero");
      check("csum_zero_value", csum_seen, 64'h0);
      mem[5] = 64'hFFFF_FFFF_FFFF_FFFF;
      run_dump(0, "csum_ones");
      check("csum_ones_value", csum_seen, 64'hFFFF_FFFF_FFFF_FFFA);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_dump

// File: doc/register_dump.md
# register_dump

Debug read-out engine on the read side of the decode-stage register memory. On a start pulse it walks all 32 architectural registers through one register-memory read port (synchronous read, 1-cycle latency) and streams each 64-bit value out on a valid/ready interface to a trace/UART/testbench sink. It runs while the core is halted, so the dump is a snapshot of register state.

## Interface
Parameters:
- `NREGS`, 32: registers walked, indices 0..NREGS-1.
- `DW`, `WORD` (64): data width.

Ports:
- `clk`, input, 1: single clock. Also clocks the connected register-memory read port.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a dump. Sampled only in IDLE.
- `busy`, output, 1: high from the cycle after `start` is accepted until DONE exits.
- `done`, output, 1: one-cycle pulse after the final beat is accepted.
- `rd_reg`, output, 5: register index driven to the register-memory read port.
- `rd_data`, input, DW: register-memory read data, valid one `clk` edge after `rd_reg`.
- `out_valid`, output, 1: beat valid.
- `out_ready`, input, 1: sink accepts the beat.
- `out_data`, output, DW: register value, or the checksum beat.
- `out_index`, output, 6: 0..31 for registers; 32 for the checksum beat.
- `out_last`, output, 1: marks the final beat of the dump.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND, CSUM, DONE.
- IDLE: when `start`=1, load `idx`=0 and go to ISSUE.
- ISSUE: `rd_reg`=`idx`. The register memory samples the index on this edge. Go to CAPTURE.
- CAPTURE: `rd_data` is valid. Latch it into `out_data`, set `out_index`=`idx` and `out_valid`=1, then go to SEND.
- SEND:
  - Hold `out_data`, `out_index` and `out_last` stable until `out_valid && out_ready`.
  - On transfer, drop `out_valid` in the next cycle.
  - If `idx`<NREGS-1: increment `idx` and go to ISSUE.
  - Otherwise go to CSUM if checksum is enabled, else DONE.
- CSUM: present the checksum beat (`out_index`=32, `out_last`=1). Hold it until transferred, then go to DONE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- `rd_reg` holds `idx` in every state. The value is latched in CAPTURE, so later `rd_data` changes do not corrupt a pending beat.
- `start` while `busy` is ignored; there is no queueing.
- Register 31 is dumped raw. There is no XZR substitution.
- Writes to the register memory during a dump are not blocked. The snapshot is atomic only when the core is halted.
- Reset, at any time including mid-dump, forces IDLE immediately:
  - `busy`, `done`, `out_valid` and `out_last` = 0.
  - `out_data` = 0, `out_index` = 0, `rd_reg` = 0, checksum accumulator = 0.

## Timing
- `start` is sampled at edge E0. ISSUE occupies E0..E1, CAPTURE occupies E1..E2, and `out_valid` is first high after E2.
- With `out_ready` held at 1, each register costs 3 cycles. A full dump is 96 cycles, plus 2 for CSUM when checksum is enabled, plus 1 for DONE.
- Each backpressure cycle adds exactly one cycle. While `out_valid`=1 and `out_ready`=0, no output changes.
- `out_last`=1 on beat 31 without checksum, or on the checksum beat with it.
- `done` is asserted in the cycle after the final transfer edge. `busy` falls together with `done` deasserting.
- `start` held high across DONE→IDLE begins a new dump one cycle after IDLE is re-entered.

## Configuration
- `REGDUMP_CHECKSUM_EN`
  - Defined: keep a DW-bit XOR of all 32 register values, cleared on `start` acceptance and updated in CAPTURE. After beat 31, emit one extra beat: `out_index`=32, `out_data`=XOR, `out_last`=1.
  - Undefined: no accumulator and no CSUM state. Beat 31 carries `out_last`; `out_index` never exceeds 31.

## Structure
- Add `REG_COUNT`=32 and `REG_ADDR_W`=5 to `constants.vh` beside `WORD`.
- State encodings are local localparams.
- No sub-module. The checksum is a single register plus an XOR and does not justify its own module.
- The testbench pairs this block with the existing register memory, with both of its clocks tied to `clk` and the initial file preloaded.

## Test plan
- Preload reg i = 64'h1000 + i, `out_ready`=1, pulse `start` → 32 beats with index i and data 64'h1000+i in order. First `out_valid` 2 edges after start is sampled. `done` at cycle 97 (99 with checksum).
- Same preload with `out_ready` toggling 1/0 each cycle → identical beat sequence. `out_data` and `out_index` are stable while stalled. Total cycles = 97 + number of stall cycles.
- `REGDUMP_CHECKSUM_EN` defined, reg i = i → beat 32 carries `out_data`=XOR(0..31)=0, `out_last`=1. With reg 5 = 64'hFFFF_FFFF_FFFF_FFFF instead, the checksum is 64'hFFFF_FFFF_FFFF_FFFA.
- `start` pulsed again at beat 10 → ignored. Exactly 32 (or 33) beats and a single `done`.
- `rst_n` asserted during SEND of beat 7 → all outputs 0 immediately. A fresh `start` after release restarts at index 0.
- Preload reg 31 = 64'hDEAD_BEEF_0000_0031 → beat 31 shows that value, not 0.
